// File: rtl/digit_serial_adder_if.sv
// digit_serial_adder_if: operand/result valid-ready handshake bundle
interface digit_serial_adder_if #(parameter int WIDTH = 16);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic Cin;
  logic Sub;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] S;
  logic Cout;
  logic Ovf;
  modport master(output in_valid, A, B, Cin, Sub, out_ready, input in_ready, out_valid, S, Cout, Ovf);
  modport slave(input in_valid, A, B, Cin, Sub, out_ready, output in_ready, out_valid, S, Cout, Ovf);
endinterface

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: add/subtract WIDTH-bit operands DIGIT bits per clock
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic clk,
  input logic rst,
  digit_serial_adder_if.slave io
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st_q, st_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [DIGIT-1:0] ad, bd;
  logic [DIGIT:0] sum;
  logic last;
  assign io.in_ready = st_q == IDLE && !rst;
  assign io.out_valid = st_q == DONE;
  assign io.S = s_q;
  assign io.Cout = cout_q;
  assign io.Ovf = ovf_q;
  always_comb begin
    ad = a_q[int'(k_q)*DIGIT +: DIGIT];
    bd = b_q[int'(k_q)*DIGIT +: DIGIT];
    sum = {1'b0, ad} + {1'b0, bd} + {{DIGIT{1'b0}}, c_q};
    last = k_q == KW'(NDIG - 1);
    st_d = st_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    k_d = k_q;
    c_d = c_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    if (st_q == IDLE && io.in_valid) begin
      a_d = io.A;
      b_d = io.B ^ {WIDTH{io.Sub}};
      c_d = io.Sub ? 1'b1 : io.Cin;
      k_d = '0;
      st_d = RUN;
    end else if (st_q == RUN) begin
      s_d[int'(k_q)*DIGIT +: DIGIT] = sum[DIGIT-1:0];
      c_d = sum[DIGIT];
      k_d = k_q + KW'(1);
      st_d = last ? DONE : RUN;
      cout_d = last ? sum[DIGIT] : cout_q;
      // carry into the MSB is recovered as a^b^s at that bit
      ovf_d = last ? a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum[DIGIT-1] ^ sum[DIGIT] : ovf_q;
    end else if (st_q == DONE && io.out_ready) begin
      st_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      k_q <= '0;
      c_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      st_q <= st_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      k_q <= k_d;
      c_q <= c_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: randomized and directed checks against an arithmetic model
module tb_digit_serial_adder;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_pass = 0;
  digit_serial_adder_if #(.WIDTH(16)) dif();
  digit_serial_adder_if #(.WIDTH(8)) dif8();
  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (.clk(clk), .rst(rst), .io(dif.slave));
  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst(rst), .io(dif8.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    int r;
    logic [15:0] s;
    logic co;
    r = sub ? $signed(a) - $signed(b) : $signed(a) + $signed(b) + int'(cin);
    s = sub ? a - b : a + b + {15'd0, cin};
    co = sub ? a >= b : (32'(a) + 32'(b) + 32'(cin)) > 32'hFFFF;
    return {r > 32767 || r < -32768, co, s};
  endfunction
  task automatic txn(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub, input int hold);
    logic [17:0] e;
    int n, low;
    e = model(a, b, cin, sub);
    n = 0;
    while (!dif.in_ready && n < 20) begin tick(); n++; end
    chk("accept_ready", 32'(dif.in_ready), 1);
    dif.A = a; dif.B = b; dif.Cin = cin; dif.Sub = sub; dif.in_valid = 1'b1;
    dif.out_ready = hold == 0;
    tick();
    dif.in_valid = 1'b0;
    dif.A = 16'($urandom); dif.B = 16'($urandom); dif.Cin = 1'($urandom); dif.Sub = 1'($urandom);
    n = 0;
    low = 0;
    while (!dif.out_valid && n < 20) begin
      low += int'(!dif.in_ready);
      tick();
      n++;
    end
    chk("latency", n, 4);
    chk("sum", 32'(dif.S), 32'(e[15:0]));
    chk("cout", 32'(dif.Cout), 32'(e[16]));
    chk("ovf", 32'(dif.Ovf), 32'(e[17]));
    for (int i = 0; i < hold; i++) begin
      low += int'(!dif.in_ready);
      dif.in_valid = 1'b1;
      dif.A = 16'($urandom); dif.B = 16'($urandom);
      tick();
      chk("bp_valid", 32'(dif.out_valid), 1);
      chk("bp_ready", 32'(dif.in_ready), 0);
      chk("bp_hold", {13'd0, dif.Ovf, dif.Cout, dif.S}, {14'd0, e});
    end
    dif.in_valid = 1'b0;
    dif.out_ready = 1'b1;
    low += int'(!dif.in_ready);
    tick();
    chk("in_ready_low_cycles", low, 5 + hold);
    chk("done_exit_valid", 32'(dif.out_valid), 0);
    chk("done_exit_ready", 32'(dif.in_ready), 1);
  endtask
  initial begin
    int n;
    logic seen;
    rst = 1'b1;
    dif.in_valid = 1'b0; dif.A = '0; dif.B = '0; dif.Cin = 1'b0; dif.Sub = 1'b0; dif.out_ready = 1'b1;
    dif8.in_valid = 1'b0; dif8.A = '0; dif8.B = '0; dif8.Cin = 1'b0; dif8.Sub = 1'b0; dif8.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(dif.in_ready), 1);
    chk("rst_out_valid", 32'(dif.out_valid), 0);
    chk("rst_state", {13'd0, dif.Ovf, dif.Cout, dif.S}, 0);
    txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    txn(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    chk("dir_ovf_add", {dif.Ovf, dif.Cout, dif.S}, {1'b1, 1'b0, 16'h8000});
    txn(16'h1234, 16'h0000, 1'b1, 1'b0, 0);
    chk("dir_cin", 32'(dif.S), 32'h1235);
    txn(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    chk("dir_borrow", {dif.Ovf, dif.Cout, dif.S}, {1'b0, 1'b0, 16'hFFFE});
    txn(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    txn(16'h8000, 16'h0001, 1'b0, 1'b1, 3);
    chk("dir_sub_ovf", {dif.Ovf, dif.Cout, dif.S}, {1'b1, 1'b1, 16'h7FFF});
    txn(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
    txn(16'h1111, 16'h2222, 1'b0, 1'b0, 0);
    dif.A = 16'h4444; dif.B = 16'h1111; dif.Cin = 1'b0; dif.Sub = 1'b0; dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(dif.in_ready), 1);
    chk("mid_rst_sum", 32'(dif.S), 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin seen |= dif.out_valid; tick(); end
    chk("mid_rst_no_valid", 32'(seen), 0);
    txn(16'h00FF, 16'h0F01, 1'b0, 1'b0, 0);
    chk("post_rst_sum", 32'(dif.S), 32'h1000);
    for (int i = 0; i < 30; i++)
      txn(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    dif8.A = 8'h80; dif8.B = 8'h80; dif8.in_valid = 1'b1;
    tick();
    dif8.in_valid = 1'b0;
    n = 0;
    while (!dif8.out_valid && n < 20) begin tick(); n++; end
    chk("n1_latency", n, 1);
    chk("n1_result", {dif8.Ovf, dif8.Cout, dif8.S}, {1'b1, 1'b1, 8'h00});
    tick();
    chk("n1_exit_ready", 32'(dif8.in_ready), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock. It generalises the fixed 4-bit ripple adder with five additions: configurable width, configurable digit size, an add/subtract mode, a signed-overflow flag, and valid/ready handshakes on both sides. It sits in datapaths where area matters more than latency. A ripple chain of DIGIT full adders is reused across WIDTH/DIGIT cycles.

## Interface
- WIDTH, 16, operand and result width in bits; must satisfy WIDTH >= 2.
- DIGIT, 4, bits added per cycle; WIDTH % DIGIT == 0 is required. NDIG = WIDTH/DIGIT.
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode present.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in; used only in add mode.
- Sub  input  1  0 selects S = A + B + Cin; 1 selects S = A - B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- S  output  WIDTH  result.
- Cout  output  1  carry out of bit WIDTH-1. In subtract mode, 1 means no borrow.
- Ovf  output  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- in_ready = 1 only in IDLE and when rst = 0. out_valid = 1 only in DONE.
- IDLE: on in_valid & in_ready, latch A, B and Sub.
  - Latched B is B ^ {WIDTH{Sub}}.
  - Carry register is loaded with Sub ? 1 : Cin.
  - Digit counter is cleared to 0. Go to RUN.
- RUN: each cycle, add digit k of A, digit k of (possibly inverted) B, and the carry register.
  - Write the DIGIT sum bits into S[k*DIGIT +: DIGIT].
  - Update the carry register with the digit carry-out.
  - Increment k.
  - On the last digit (k = NDIG-1):
    - Cout = digit carry-out.
    - Ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
    - Go to DONE.
- DONE: hold S, Cout and Ovf stable. When out_ready = 1, go to IDLE next cycle.
- in_valid is ignored outside IDLE. Operand inputs are don't-care after the accept cycle.
- S, Cout and Ovf keep their last values in IDLE; they are valid only while out_valid = 1.
- NDIG = 1 is legal: RUN lasts one cycle.
- Reset (any state, including mid-RUN or DONE):
  - state = IDLE; S = 0; Cout = 0; Ovf = 0; out_valid = 0; carry and counter = 0.
  - A pending result is discarded and never presented.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Accept at edge T. RUN spans edges T+1 .. T+NDIG. out_valid rises after edge T+NDIG.
- Latency is NDIG cycles from accept to out_valid.
- Handshake:
  - If out_ready = 1 in the first DONE cycle, out_valid lasts exactly 1 cycle.
  - in_ready returns 1 the following cycle.
- Minimum initiation interval is NDIG + 2 cycles: accept, NDIG RUN cycles, one DONE cycle, then IDLE.
- in_ready is a combinational decode of state. out_valid is a combinational decode of state. S, Cout and Ovf come from registers.
- rst asserted at edge E: after E, out_valid = 0 and in_ready = 1, provided rst is deasserted.

## Test plan
All scenarios use WIDTH = 16, DIGIT = 4 unless noted.
- Add with carry-out: A = 0xFFFF, B = 0x0001, Cin = 0, Sub = 0, out_ready = 1.
  - out_valid exactly 4 cycles after accept.
  - S = 0x0000, Cout = 1, Ovf = 0.
  - in_ready low for 5 cycles.
- Signed overflow, add:
  - A = 0x7FFF, B = 0x0001, Cin = 0 -> S = 0x8000, Cout = 0, Ovf = 1.
  - A = 0x1234, B = 0x0000, Cin = 1 -> S = 0x1235.
- Subtract with borrow: Sub = 1.
  - A = 0x0005, B = 0x0007 -> S = 0xFFFE, Cout = 0, Ovf = 0.
  - A = 0x8000, B = 0x0001 -> S = 0x7FFF, Cout = 1, Ovf = 1.
  - Cin = 1 must not change either result.
- Backpressure: out_ready = 0 for 3 cycles in DONE, with in_valid = 1 and new operands driven.
  - S, Cout and Ovf stable; out_valid held; in_ready = 0; new operands not accepted.
  - After out_ready = 1, the next accept produces the new operands' result.
- Reset mid-RUN: assert rst for 1 cycle on the 2nd RUN cycle.
  - out_valid never rises for that transaction.
  - S = 0; in_ready = 1 the cycle after rst deasserts.
  - The next transaction (0x00FF + 0x0F01 -> 0x1000) is correct.
- NDIG = 1 config (WIDTH = 8, DIGIT = 8): 0x80 + 0x80 -> S = 0x00, Cout = 1, Ovf = 1, latency 1.
